// File: rtl/pwm_tone_seq_if.sv
// Note-command handshake and tone outputs of pwm_tone_seq.
// The sequencer side drives commands; the tone block returns ready and the
// buzzer-facing status.
interface pwm_tone_seq_if #(
   parameter int DUTY_W = 8,
   parameter int DUR_W  = 8
);
   logic              note_valid;
   logic              note_ready;
   logic [2:0]        note;
   logic [1:0]        octave;
   logic [DUTY_W-1:0] duty;
   logic [DUR_W-1:0]  dur;
   logic              pwm_out;
   logic              busy;
   logic              done;

   modport master (
      output note_valid, note, octave, duty, dur,
      input  note_ready, pwm_out, busy, done
   );

   modport slave (
      input  note_valid, note, octave, duty, dur,
      output note_ready, pwm_out, busy, done
   );
endinterface

// File: rtl/pwm_tone_seq.sv
// PWM tone sequencer: accepts note commands over a valid/ready handshake and
// plays each one for a programmable number of tone periods. A new note can be
// loaded on the last clock of the current one, so back-to-back notes switch
// exactly on a period boundary with no idle cycle.
module pwm_tone_seq #(
   parameter int CNT_W  = 16,
   parameter int DUTY_W = 8,
   parameter int DUR_W  = 8,
   parameter int P_DO   = 15267,
   parameter int P_RE   = 13605,
   parameter int P_MI   = 12121,
   parameter int P_FA   = 11461,
   parameter int P_SO   = 10230,
   parameter int P_LA   = 9090,
   parameter int P_SI   = 8097,
   parameter int P_REST = 401
) (
   input  logic           clk,
   input  logic           rst_n,
   pwm_tone_seq_if.slave  bus
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_PLAY = 1'b1
   } state_t;

   // Base period for a note; the octave shift truncates to CNT_W and very
   // short periods are clamped to 2 so the waveform always has a low phase.
   function automatic logic [CNT_W-1:0] calc_period(input logic [2:0] n,
                                                    input logic [1:0] oct);
      logic [CNT_W-1:0] base;
      logic [CNT_W-1:0] p;
      case (n)
         3'd0:    base = CNT_W'(P_REST);
         3'd1:    base = CNT_W'(P_DO);
         3'd2:    base = CNT_W'(P_RE);
         3'd3:    base = CNT_W'(P_MI);
         3'd4:    base = CNT_W'(P_FA);
         3'd5:    base = CNT_W'(P_SO);
         3'd6:    base = CNT_W'(P_LA);
         default: base = CNT_W'(P_SI);
      endcase
      case (oct)
         2'b00:   p = base << 1;
         2'b01:   p = base;
         2'b11:   p = base >> 1;
         default: p = base >> 2;
      endcase
      if (p < CNT_W'(2)) begin
         p = CNT_W'(2);
      end
      return p;
   endfunction

   // High time is taken from the full-width product so no precision is lost
   // before the shift; duty < 2**DUTY_W keeps it strictly below the period.
   function automatic logic [CNT_W-1:0] calc_high(input logic [CNT_W-1:0]  p,
                                                  input logic [DUTY_W-1:0] d);
      logic [CNT_W+DUTY_W-1:0] prod;
      prod = {{DUTY_W{1'b0}}, p} * {{CNT_W{1'b0}}, d};
      return prod[CNT_W+DUTY_W-1:DUTY_W];
   endfunction

   // A duration of 0 plays a single period, same as 1.
   function automatic logic [DUR_W-1:0] calc_last_per(input logic [DUR_W-1:0] d);
      return (d == '0) ? '0 : d - DUR_W'(1);
   endfunction

   // Only the values needed while playing are kept: octave, duty and dur are
   // folded into period, high time and last-period index at acceptance.
   state_t            state_q,    state_d;
   logic [2:0]        note_q,     note_d;
   logic [CNT_W-1:0]  period_q,   period_d;
   logic [CNT_W-1:0]  high_q,     high_d;
   logic [DUR_W-1:0]  last_per_q, last_per_d;
   logic [CNT_W-1:0]  phase_q,    phase_d;
   logic [DUR_W-1:0]  per_cnt_q,  per_cnt_d;
   logic              pwm_q,      pwm_d;

   logic              wrap;
   logic              last_cycle;
   logic              accept;
   logic [CNT_W-1:0]  cmd_period;
   logic [CNT_W-1:0]  cmd_high;
   logic [DUR_W-1:0]  cmd_last_per;

   // Period-boundary and end-of-note detection from the running counters.
   always_comb begin
      wrap       = (phase_q == period_q - CNT_W'(1));
      last_cycle = (state_q == S_PLAY) && wrap && (per_cnt_q == last_per_q);
   end

   // Ready only when idle or on the final clock of a note, never during reset.
   always_comb begin
      bus.note_ready = rst_n && ((state_q == S_IDLE) || last_cycle);
      bus.done       = rst_n && last_cycle;
      bus.busy       = (state_q == S_PLAY);
      bus.pwm_out    = pwm_q;
      accept         = bus.note_valid && bus.note_ready;
   end

   // Timing parameters of the command currently offered on the bus.
   always_comb begin
      cmd_period   = calc_period(bus.note, bus.octave);
      cmd_high     = calc_high(cmd_period, bus.duty);
      cmd_last_per = calc_last_per(bus.dur);
   end

   // Next-state: load on accept, otherwise step phase and period counters.
   always_comb begin
      state_d    = state_q;
      note_d     = note_q;
      period_d   = period_q;
      high_d     = high_q;
      last_per_d = last_per_q;
      phase_d    = phase_q;
      per_cnt_d  = per_cnt_q;
      // pwm_out reflects the phase of the previous cycle; rests stay low.
      pwm_d      = (state_q == S_PLAY) && (note_q != 3'd0) && (phase_q < high_q);

      if (accept) begin
         state_d    = S_PLAY;
         note_d     = bus.note;
         period_d   = cmd_period;
         high_d     = cmd_high;
         last_per_d = cmd_last_per;
         phase_d    = '0;
         per_cnt_d  = '0;
      end else if (state_q == S_PLAY) begin
         if (last_cycle) begin
            state_d   = S_IDLE;
            phase_d   = '0;
            per_cnt_d = '0;
         end else if (wrap) begin
            phase_d   = '0;
            per_cnt_d = per_cnt_q + DUR_W'(1);
         end else begin
            phase_d   = phase_q + CNT_W'(1);
         end
      end
   end

   // State register; reset aborts any note and clears the latched command.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         note_q     <= '0;
         period_q   <= '0;
         high_q     <= '0;
         last_per_q <= '0;
         phase_q    <= '0;
         per_cnt_q  <= '0;
         pwm_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         note_q     <= note_d;
         period_q   <= period_d;
         high_q     <= high_d;
         last_per_q <= last_per_d;
         phase_q    <= phase_d;
         per_cnt_q  <= per_cnt_d;
         pwm_q      <= pwm_d;
      end
   end

endmodule
